// File: rtl/pi_sched_pkg.sv
// Shared definitions for the PI channel scheduler: sizes, gains, FSM
// encoding and sign-magnitude arithmetic helpers.
package pi_sched_pkg;

  localparam int N_CH    = 4;
  localparam int N_WIDTH = 17;
  localparam int Q_WIDTH = 8;
  localparam int ACC_W   = N_WIDTH + 10;
  localparam int CH_W    = $clog2(N_CH);
  localparam int INT_W   = ACC_W - 1 - Q_WIDTH;

  localparam logic [N_WIDTH-1:0] K_P = 17'h00014;
  localparam logic [N_WIDTH-1:0] K_I = 17'h00014;

  localparam int unsigned PWM_MAX = 200;
  localparam int unsigned PWM_MIN = 5;

  // Anti-windup value: PWM_MAX.0 as a positive ACC_W word
  localparam logic [ACC_W-1:0] U_MAX = ACC_W'(PWM_MAX * (2 ** Q_WIDTH));

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SNAP  = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_MUL_P = 3'd3;
  localparam logic [2:0] ST_MUL_I = 3'd4;
  localparam logic [2:0] ST_ACC   = 3'd5;
  localparam logic [2:0] ST_STORE = 3'd6;
  localparam logic [2:0] ST_DONE  = 3'd7;

  // Sign-magnitude add; the result takes the sign of the larger magnitude
  // and a zero result is always +0.
  function automatic logic [ACC_W-1:0] sm_add(input logic [ACC_W-1:0] a,
                                              input logic [ACC_W-1:0] b);
    logic [ACC_W-2:0] mag;
    logic             sgn;
    if (a[ACC_W-1] == b[ACC_W-1]) begin
      mag = a[ACC_W-2:0] + b[ACC_W-2:0];
      sgn = a[ACC_W-1];
    end else if (a[ACC_W-2:0] >= b[ACC_W-2:0]) begin
      mag = a[ACC_W-2:0] - b[ACC_W-2:0];
      sgn = a[ACC_W-1];
    end else begin
      mag = b[ACC_W-2:0] - a[ACC_W-2:0];
      sgn = b[ACC_W-1];
    end
    return {sgn & (|mag), mag};
  endfunction

  // Sign-magnitude subtract a - b (negate b, then add)
  function automatic logic [ACC_W-1:0] sm_sub(input logic [ACC_W-1:0] a,
                                              input logic [ACC_W-1:0] b);
    return sm_add(a, {~b[ACC_W-1], b[ACC_W-2:0]});
  endfunction

  // Error word setpoint - measured from two unsigned Q8 values
  function automatic logic [N_WIDTH-1:0] sm_err(input logic [N_WIDTH-2:0] sp,
                                                input logic [N_WIDTH-2:0] ms);
    logic [ACC_W-1:0] d;
    d = sm_sub({{(ACC_W-N_WIDTH+1){1'b0}}, sp}, {{(ACC_W-N_WIDTH+1){1'b0}}, ms});
    return {d[ACC_W-1], (N_WIDTH-1)'(d[ACC_W-2:0])};
  endfunction

  // Q8 sign-magnitude multiply with truncation; zero product is +0
  function automatic logic [ACC_W-1:0] sm_mul(input logic [N_WIDTH-1:0] a,
                                              input logic [N_WIDTH-1:0] b);
    logic [2*(N_WIDTH-1)-1:0] prod;
    logic [ACC_W-2:0]         mag;
    prod = a[N_WIDTH-2:0] * b[N_WIDTH-2:0];
    mag  = (ACC_W-1)'(prod >> Q_WIDTH);
    return {(a[N_WIDTH-1] ^ b[N_WIDTH-1]) & (|mag), mag};
  endfunction

endpackage

// File: rtl/pi_sm_datapath.sv
// Shared PI datapath: one error subtractor, one multiplier and one
// accumulator adder, stepped by the scheduler state.
module pi_sm_datapath
  import pi_sched_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         state_i,
  input  logic [N_WIDTH-2:0] sp_i,
  input  logic [N_WIDTH-2:0] ms_i,
  input  logic [N_WIDTH-1:0] e_k1_i,
  input  logic [ACC_W-1:0]   u_k1_i,
  output logic [N_WIDTH-1:0] e_o,
  output logic [ACC_W-1:0]   acc_o
);

  logic [N_WIDTH-1:0] e_q, e_d, err_s;
  logic [ACC_W-1:0]   p_q, p_d, i_q, i_d, acc_q, acc_d;
  logic [N_WIDTH-1:0] mul_a_s, mul_b_s;
  logic [ACC_W-1:0]   add_a_s, add_b_s, mul_s, add_s;

  assign err_s = sm_err(sp_i, ms_i);
  assign mul_s = sm_mul(mul_a_s, mul_b_s);
  assign add_s = sm_add(add_a_s, add_b_s);
  assign e_o   = e_q;
  assign acc_o = acc_q;

  // Operand muxing: P term uses e_k, I term uses e_k1; adder first folds P into u_k1, then adds I
  always_comb begin
    mul_a_s = K_P;
    mul_b_s = e_q;
    add_a_s = u_k1_i;
    add_b_s = p_q;
    case (state_i)
      ST_MUL_I: begin
        mul_a_s = K_I;
        mul_b_s = e_k1_i;
      end
      ST_ACC: begin
        add_a_s = acc_q;
        add_b_s = i_q;
      end
      default: begin
        mul_a_s = K_P;
        mul_b_s = e_q;
      end
    endcase
  end

  // Next-state of the working registers for the current channel slot
  always_comb begin
    e_d   = e_q;
    p_d   = p_q;
    i_d   = i_q;
    acc_d = acc_q;
    case (state_i)
      ST_LOAD:  e_d = err_s;
      ST_MUL_P: p_d = mul_s;
      ST_MUL_I: begin
        i_d   = mul_s;
        acc_d = add_s;
      end
      ST_ACC:   acc_d = add_s;
      default:  e_d = e_q;
    endcase
  end

  // Working registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_q   <= '0;
      p_q   <= '0;
      i_q   <= '0;
      acc_q <= '0;
    end else begin
      e_q   <= e_d;
      p_q   <= p_d;
      i_q   <= i_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/pi_channel_scheduler.sv
// Time-multiplexed PI controller for N_CH wheel motors. Each accepted tick
// snapshots the inputs, runs every channel through the shared datapath in a
// fixed 5-cycle slot and publishes all PWM lanes together.
module pi_channel_scheduler
  import pi_sched_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        sample_tick,
  input  logic [N_CH-1:0]             enable,
  input  logic [N_CH*(N_WIDTH-1)-1:0] setpoint,
  input  logic [N_CH*(N_WIDTH-1)-1:0] measured,
  input  logic                        clear_overrun,
  output logic [N_CH*8-1:0]           pwm_cmd,
  output logic                        pwm_valid,
  output logic                        busy,
  output logic                        overrun
);

  logic [2:0]                  state_q, state_d;
  logic [CH_W-1:0]             ch_q, ch_d;
  logic [N_CH-1:0]             en_snap_q;
  logic [N_CH*(N_WIDTH-1)-1:0] sp_snap_q, ms_snap_q;
  logic [N_WIDTH-1:0]          e_k1_q [N_CH];
  logic [ACC_W-1:0]            u_k1_q [N_CH];
  logic [7:0]                  stage_q [N_CH];
  logic [N_CH*8-1:0]           pwm_cmd_q;
  logic                        pwm_valid_q, busy_q, overrun_q;

  logic [N_WIDTH-2:0] sp_cur_s, ms_cur_s;
  logic [N_WIDTH-1:0] e_s, e_new_s;
  logic [ACC_W-1:0]   acc_s, u_new_s;
  logic [INT_W-1:0]   int_s;
  logic [7:0]         pwm_new_s;
  logic               last_s;

  assign sp_cur_s = sp_snap_q[int'(ch_q)*(N_WIDTH-1) +: (N_WIDTH-1)];
  assign ms_cur_s = ms_snap_q[int'(ch_q)*(N_WIDTH-1) +: (N_WIDTH-1)];
  assign int_s    = acc_s[ACC_W-2:Q_WIDTH];
  assign last_s   = (ch_q == CH_W'(N_CH-1));

  assign pwm_cmd   = pwm_cmd_q;
  assign pwm_valid = pwm_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

  pi_sm_datapath u_dp (
    .clk     (clk),
    .reset_n (reset_n),
    .state_i (state_q),
    .sp_i    (sp_cur_s),
    .ms_i    (ms_cur_s),
    .e_k1_i  (e_k1_q[ch_q]),
    .u_k1_i  (u_k1_q[ch_q]),
    .e_o     (e_s),
    .acc_o   (acc_s)
  );

  // Sequencer: every channel takes LOAD..STORE regardless of enable, giving fixed latency
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    case (state_q)
      ST_IDLE: begin
        if (sample_tick) state_d = ST_SNAP;
        else             state_d = ST_IDLE;
      end
      ST_SNAP: begin
        state_d = ST_LOAD;
        ch_d    = '0;
      end
      ST_LOAD:  state_d = ST_MUL_P;
      ST_MUL_P: state_d = ST_MUL_I;
      ST_MUL_I: state_d = ST_ACC;
      ST_ACC:   state_d = ST_STORE;
      ST_STORE: begin
        if (last_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_LOAD;
          ch_d    = ch_q + 1'b1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output shaping for the channel in its STORE slot: negative clamp, anti-windup, deadband
  always_comb begin
    pwm_new_s = 8'd0;
    u_new_s   = '0;
    e_new_s   = '0;
    if (!en_snap_q[ch_q]) begin
      pwm_new_s = 8'd0;
    end else begin
      e_new_s = e_s;
      if (acc_s[ACC_W-1]) begin
        pwm_new_s = 8'd0;
        u_new_s   = '0;
      end else if (int_s >= INT_W'(PWM_MAX)) begin
        pwm_new_s = 8'(PWM_MAX);
        u_new_s   = U_MAX;
      end else if (int_s <= INT_W'(PWM_MIN)) begin
        pwm_new_s = 8'd0;
        u_new_s   = acc_s;
      end else begin
        pwm_new_s = int_s[7:0];
        u_new_s   = acc_s;
      end
    end
  end

  // FSM and channel counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  end

  // Input snapshot taken with the accepted tick so later input changes cannot leak in
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_snap_q <= '0;
      sp_snap_q <= '0;
      ms_snap_q <= '0;
    end else if (state_q == ST_IDLE && sample_tick) begin
      en_snap_q <= enable;
      sp_snap_q <= setpoint;
      ms_snap_q <= measured;
    end
  end

  // Per-channel loop memory and staged PWM values
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < N_CH; c++) begin
        e_k1_q[c]  <= '0;
        u_k1_q[c]  <= '0;
        stage_q[c] <= 8'd0;
      end
    end else if (state_q == ST_STORE) begin
      e_k1_q[ch_q]  <= e_new_s;
      u_k1_q[ch_q]  <= u_new_s;
      stage_q[ch_q] <= pwm_new_s;
    end
  end

  // Published outputs; the last channel's value bypasses the stage so all lanes move together
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cmd_q   <= '0;
      pwm_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      pwm_valid_q <= (state_q == ST_STORE) && last_s;
      busy_q      <= (state_d != ST_IDLE);
      if (state_q == ST_STORE && last_s) begin
        for (int c = 0; c < N_CH - 1; c++) begin
          pwm_cmd_q[c*8 +: 8] <= stage_q[c];
        end
        pwm_cmd_q[(N_CH-1)*8 +: 8] <= pwm_new_s;
      end
      if (sample_tick && state_q != ST_IDLE) begin
        overrun_q <= 1'b1;
      end else if (clear_overrun) begin
        overrun_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pi_channel_scheduler.sv
// Self-checking bench for pi_channel_scheduler: an integer PI model feeds a
// scoreboard queue at every tick; a monitor compares on each pwm_valid.
module tb_pi_channel_scheduler;

  logic        clk = 1'b0;
  logic        reset_n, sample_tick, clear_overrun;
  logic [3:0]  enable;
  logic [63:0] setpoint, measured;
  logic [31:0] pwm_cmd;
  logic        pwm_valid, busy, overrun;

  int total = 0;
  int bad   = 0;

  longint      m_e1 [4];
  longint      m_u1 [4];
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  pi_channel_scheduler dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sample_tick   (sample_tick),
    .enable        (enable),
    .setpoint      (setpoint),
    .measured      (measured),
    .clear_overrun (clear_overrun),
    .pwm_cmd       (pwm_cmd),
    .pwm_valid     (pwm_valid),
    .busy          (busy),
    .overrun       (overrun)
  );

  function automatic longint kmul(input longint e);
    if (e < 0) return -(((-e) * 20) / 256);
    else       return (e * 20) / 256;
  endfunction

  // Reference PI step on the current inputs; result pushed to the scoreboard
  task automatic push_expected();
    logic [31:0] v;
    longint sp, ms, e, u, pw;
    v = 32'd0;
    for (int c = 0; c < 4; c++) begin
      sp = longint'(setpoint[c*16 +: 16]);
      ms = longint'(measured[c*16 +: 16]);
      e  = sp - ms;
      u  = m_u1[c] + kmul(e) + kmul(m_e1[c]);
      if (!enable[c]) begin
        pw = 0; m_e1[c] = 0; m_u1[c] = 0;
      end else begin
        m_e1[c] = e;
        if (u < 0) begin
          pw = 0; m_u1[c] = 0;
        end else if (u / 256 >= 200) begin
          pw = 200; m_u1[c] = 200 * 256;
        end else if (u / 256 <= 5) begin
          pw = 0; m_u1[c] = u;
        end else begin
          pw = u / 256; m_u1[c] = u;
        end
      end
      v[c*8 +: 8] = 8'(pw);
    end
    exp_q.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch();
    sample_tick = 1'b1;
    push_expected();
    step();
    sample_tick = 1'b0;
  endtask

  // Bounded wait for pwm_valid; lat is the cycle number relative to the tick cycle
  task automatic wait_valid(input int start, output int lat);
    lat = start;
    while (pwm_valid !== 1'b1 && lat < 60) begin
      step();
      lat++;
    end
    step();
  endtask

  task automatic do_reset();
    reset_n = 1'b0; sample_tick = 1'b0; clear_overrun = 1'b0;
    enable = 4'd0; setpoint = 64'd0; measured = 64'd0;
    for (int c = 0; c < 4; c++) begin m_e1[c] = 0; m_u1[c] = 0; end
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    step();
  endtask

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (reset_n === 1'b1 && pwm_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_extra: pwm_valid with pwm_cmd=%h, required no update", pwm_cmd);
      end else begin
        logic [31:0] ex;
        ex = exp_q.pop_front();
        if (pwm_cmd !== ex) begin
          bad++;
          $display("FAIL scoreboard_pwm: pwm_cmd=%h required %h", pwm_cmd, ex);
        end
      end
    end
  end

  task automatic test_reset();
    do_reset();
    total++; if (pwm_cmd !== 32'd0) begin bad++; $display("FAIL reset_pwm: %h required 0", pwm_cmd); end
    total++; if (pwm_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: %b required 0", pwm_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: %b required 0", busy); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: %b required 0", overrun); end
  endtask

  task automatic test_basic();
    int lat;
    enable = 4'b0001; setpoint = 64'h0000_0000_0000_6400; measured = 64'd0;
    launch();
    wait_valid(1, lat);
    total++; if (lat !== 22) begin bad++; $display("FAIL basic_latency: %0d required 22", lat); end
    total++; if (pwm_cmd !== 32'h0000_0007) begin bad++; $display("FAIL basic_tick1: %h required 00000007", pwm_cmd); end
    launch();
    wait_valid(1, lat);
    total++; if (pwm_cmd !== 32'h0000_0017) begin bad++; $display("FAIL basic_tick2: %h required 00000017", pwm_cmd); end
  endtask

  task automatic test_latency();
    logic [31:0] prev;
    enable   = 4'b1111;
    setpoint = {16'h3000, 16'h2000, 16'h1800, 16'h0A00};
    measured = {16'h1000, 16'h2800, 16'h0200, 16'h0A00};
    prev = pwm_cmd;
    launch();
    for (int k = 1; k <= 23; k++) begin
      total++;
      if (busy !== (k <= 22)) begin bad++; $display("FAIL lat_busy c%0d: %b required %b", k, busy, k <= 22); end
      total++;
      if (pwm_valid !== (k == 22)) begin bad++; $display("FAIL lat_valid c%0d: %b required %b", k, pwm_valid, k == 22); end
      if (k < 22) begin
        total++;
        if (pwm_cmd !== prev) begin bad++; $display("FAIL lat_stable c%0d: %h required %h", k, pwm_cmd, prev); end
      end
      if (k == 5) setpoint = {16'hFFFF, 16'h0000, 16'h7777, 16'h1234};
      step();
    end
  endtask

  task automatic test_clamp();
    int lat;
    do_reset();
    enable = 4'b0001; setpoint = 64'h0000_0000_0000_FF00; measured = 64'd0;
    for (int t = 0; t < 8; t++) begin
      launch(); wait_valid(1, lat);
      total++; if (pwm_cmd[7:0] > 8'd200) begin bad++; $display("FAIL clamp_rise t%0d: %0d required <=200", t, pwm_cmd[7:0]); end
    end
    total++; if (pwm_cmd[7:0] !== 8'd200) begin bad++; $display("FAIL clamp_sat: %0d required 200", pwm_cmd[7:0]); end
    measured = setpoint;
    for (int t = 0; t < 3; t++) begin
      launch(); wait_valid(1, lat);
      total++; if (pwm_cmd[7:0] !== 8'd200) begin bad++; $display("FAIL clamp_hold t%0d: %0d required 200", t, pwm_cmd[7:0]); end
    end
    measured = 64'h0000_0000_0000_FFFF;
    launch(); wait_valid(1, lat);
    total++; if (pwm_cmd[7:0] >= 8'd200) begin bad++; $display("FAIL clamp_drop: %0d required <200", pwm_cmd[7:0]); end
  endtask

  task automatic test_deadband();
    int lat;
    logic [7:0] want [3];
    want[0] = 8'd0; want[1] = 8'd0; want[2] = 8'd6;
    do_reset();
    enable = 4'b0001; setpoint = 64'h0000_0000_0000_6400; measured = 64'h0000_0000_0000_9600;
    launch(); wait_valid(1, lat);
    total++; if (pwm_cmd[7:0] !== 8'd0) begin bad++; $display("FAIL neg_err: %0d required 0", pwm_cmd[7:0]); end
    setpoint = 64'h0000_0000_0000_7800; measured = 64'h0000_0000_0000_6400;
    for (int t = 0; t < 3; t++) begin
      launch(); wait_valid(1, lat);
      total++; if (pwm_cmd[7:0] !== want[t]) begin bad++; $display("FAIL deadband t%0d: %0d required %0d", t, pwm_cmd[7:0], want[t]); end
    end
  endtask

  task automatic test_overrun();
    int lat, extra;
    launch();
    repeat (9) step();
    sample_tick = 1'b1; step(); sample_tick = 1'b0;
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_set: %b required 1", overrun); end
    wait_valid(11, lat);
    total++; if (lat !== 22) begin bad++; $display("FAIL overrun_latency: %0d required 22", lat); end
    extra = 0;
    for (int k = 0; k < 30; k++) begin
      if (pwm_valid === 1'b1 || busy === 1'b1) extra++;
      step();
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL overrun_restart: %0d busy cycles required 0", extra); end
    clear_overrun = 1'b1; step(); clear_overrun = 1'b0;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_clear: %b required 0", overrun); end
    launch();
    repeat (3) step();
    sample_tick = 1'b1; clear_overrun = 1'b1; step();
    sample_tick = 1'b0; clear_overrun = 1'b0;
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_setwins: %b required 1", overrun); end
    wait_valid(5, lat);
    clear_overrun = 1'b1; step(); clear_overrun = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    do_reset();
    enable = 4'b0001; setpoint = 64'h0000_0000_0000_6400; measured = 64'd0;
    launch(); wait_valid(1, lat);
    launch();
    repeat (11) step();
    reset_n = 1'b0;
    for (int c = 0; c < 4; c++) begin m_e1[c] = 0; m_u1[c] = 0; end
    exp_q.delete();
    #2;
    total++; if (pwm_cmd !== 32'd0) begin bad++; $display("FAIL midreset_pwm: %h required 0", pwm_cmd); end
    total++; if (busy !== 1'b0 || pwm_valid !== 1'b0) begin bad++; $display("FAIL midreset_flags: busy=%b valid=%b required 0 0", busy, pwm_valid); end
    step();
    reset_n = 1'b1;
    step();
    launch(); wait_valid(1, lat);
    total++; if (lat !== 22) begin bad++; $display("FAIL midreset_latency: %0d required 22", lat); end
    total++; if (pwm_cmd !== 32'h0000_0007) begin bad++; $display("FAIL midreset_first: %h required 00000007", pwm_cmd); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; sample_tick = 1'b0; clear_overrun = 1'b0;
    enable = 4'd0; setpoint = 64'd0; measured = 64'd0;
    test_reset();
    test_basic();
    test_latency();
    test_clamp();
    test_deadband();
    test_overrun();
    test_reset_mid();
    step();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_left: %0d pending required 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
